// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pkg
//  Description : Shared types and sizing for the sequential right shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned NUM_STAGES = 5;
  // Width of the stage counter (must hold 0..NUM_STAGES-1).
  localparam int unsigned STAGE_W    = 3;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when the counter points at the final logarithmic stage.
  function automatic logic is_last_stage(input logic [STAGE_W-1:0] k);
    return (k == LAST_STAGE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_2to1_1bit.sv
`default_nettype none
// ============================================================================
//  Module      : mux_2to1_1bit
//  Description : Single-bit 2:1 multiplexer cell shared with the left shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_2to1_1bit (
  input  logic in0_i,
  input  logic in1_i,
  input  logic sel_i,
  output logic out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule
`default_nettype wire

// File: rtl/shr_stage_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : shr_stage_32bit
//  Description : One combinational right-shift layer. Shifts the input right
//                by 2^k (k = 0..4) when enabled, inserting the fill bit at
//                the top; passes data through unchanged otherwise. A single
//                instance is time-shared across all five stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module shr_stage_32bit
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic [STAGE_W-1:0] k_i,
  input  logic               en_i,
  input  logic               fill_i,
  output logic [DATA_W-1:0]  data_o
);

  logic [DATA_W-1:0] shifted;

  // Candidate value for the selected distance; unused codes pass through.
  always_comb begin
    shifted = data_i;
    case (k_i)
      3'd0:    shifted = {fill_i,           data_i[31:1]};
      3'd1:    shifted = {{2{fill_i}},      data_i[31:2]};
      3'd2:    shifted = {{4{fill_i}},      data_i[31:4]};
      3'd3:    shifted = {{8{fill_i}},      data_i[31:8]};
      3'd4:    shifted = {{16{fill_i}},     data_i[31:16]};
      default: shifted = data_i;
    endcase
  end

  // Bypass layer: one mux cell per bit chooses hold vs. shifted.
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    mux_2to1_1bit u_mux (
      .in0_i (data_i[i]),
      .in1_i (shifted[i]),
      .sel_i (en_i),
      .out_o (data_o[i])
    );
  end

endmodule
`default_nettype wire

// File: rtl/shift_right_seq_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_right_seq_32bit
//  Description : Multi-cycle 32-bit right shifter (SRL/SRLV, optionally
//                SRA/SRAV). Applies one logarithmic stage per clock from a
//                latched operand; fixed latency of 6 cycles from start to
//                done. Start/busy/done handshake toward the ALU control.
//  Config      : SHR_SRA_EN - when defined, arith selects sign fill;
//                when undefined the unit is SRL-only (arith ignored).
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_right_seq_32bit
  import shifter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [SHAMT_W-1:0]  shiftamt,
  input  logic                arith,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result
);

  state_t               state_q;
  logic [DATA_W-1:0]    work_q;
  logic [DATA_W-1:0]    work_d;
  logic [SHAMT_W-1:0]   shamt_q;
  logic                 arith_q;
  logic [STAGE_W-1:0]   k_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DATA_W-1:0]    result_q;
  logic                 stage_en;
  logic                 stage_fill;

  // Working bit 31 never changes during an arithmetic shift, so it is the
  // original sign of a and serves directly as the fill bit.
`ifdef SHR_SRA_EN
  assign stage_fill = arith_q & work_q[DATA_W-1];
`else
  logic unused_arith;
  assign unused_arith = arith_q;
  assign stage_fill   = 1'b0;
`endif

  assign stage_en = shamt_q[k_q];

  shr_stage_32bit u_stage (
    .data_i (work_q),
    .k_i    (k_q),
    .en_i   (stage_en),
    .fill_i (stage_fill),
    .data_o (work_d)
  );

  // Control FSM with registered busy/done decodes and the datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      shamt_q  <= '0;
      arith_q  <= 1'b0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            work_q  <= a;
            shamt_q <= shiftamt;
            arith_q <= arith;
            k_q     <= '0;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        SHIFT: begin
          // Every stage runs regardless of its shiftamt bit: fixed latency.
          work_q <= work_d;
          if (is_last_stage(k_q)) begin
            result_q <= work_d;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_seq_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_right_seq_32bit
//  Description : Directed self-checking bench for shift_right_seq_32bit with
//                a result scoreboard. Honours SHR_SRA_EN like the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_right_seq_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shiftamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  shift_right_seq_32bit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .shiftamt (shiftamt),
    .arith    (arith),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Advance one cycle; drive and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      total++;
      assert (1'b0) else begin
        bad++;
        $error("FAIL %s: observed=done expected=no pending result", tag);
      end
    end else begin
      exp = sb_q.pop_front();
      check({tag, " result"}, result, exp);
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [4:0] sv, input logic arv,
                       input logic [31:0] exp);
    a        = av;
    shiftamt = sv;
    arith    = arv;
    start    = 1'b1;
    sb_q.push_back(exp);
  endtask

  // Called in cycle N+lat0; waits for done, checking busy while shifting.
  task automatic wait_done(input int lat0, input string tag);
    int lat = lat0;
    bit seen = 1'b0;
    while (lat <= 20) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check({tag, " busy"}, {31'b0, busy}, 32'd1);
      step();
      lat++;
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL %s timeout: observed=no done expected=done by N+6", tag);
    end
    if (seen) begin
      check({tag, " latency"}, 32'(lat), 32'd6);
      check({tag, " busy@done"}, {31'b0, busy}, 32'd0);
      pop_check(tag);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; shiftamt = '0; arith = 1'b0;
    step(); step();
    check("reset busy",   {31'b0, busy}, 32'd0);
    check("reset done",   {31'b0, done}, 32'd0);
    check("reset result", result,        32'h0);
    rst = 1'b0;
    step();

    // SRL 0x80000000 by 31
    issue(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    step(); start = 1'b0;
    wait_done(1, "srl31");
    step();
    check("srl31 done pulse", {31'b0, done}, 32'd0);
    check("srl31 hold",       result,        32'h0000_0001);

    // SRA 0x80000000 by 4
`ifdef SHR_SRA_EN
    issue(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
`else
    issue(32'h8000_0000, 5'd4, 1'b1, 32'h0800_0000);
`endif
    step(); start = 1'b0;
    wait_done(1, "sra4");
    step();

    // Zero shift keeps the operand, same latency
    issue(32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
    step(); start = 1'b0;
    wait_done(1, "sh0");
    step();

    // Mixed pattern: logical by 13
    issue(32'hC3A5_F00F, 5'd13, 1'b0, 32'h0006_1D2F);
    step(); start = 1'b0;
    wait_done(1, "srl13");
    step();

    // Input changes and a stray start during SHIFT are ignored
    issue(32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF);
    step(); start = 1'b0;                   // N+1
    step();                                 // N+2
    start = 1'b1; a = 32'hFFFF_FFFF; shiftamt = 5'd1;
    step();                                 // N+3
    start = 1'b0;
    wait_done(3, "midchg");
    for (int i = 0; i < 8; i++) begin
      step();
      check("midchg no 2nd done", {31'b0, done}, 32'd0);
      check("midchg hold",        result,        32'h0000_00FF);
    end

    // Reset during SHIFT aborts and clears everything
    issue(32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678);
    step(); start = 1'b0;
    wait_done(1, "pre-rst");
    step();
    a = 32'hFFFF_0000; shiftamt = 5'd3; arith = 1'b0; start = 1'b1;   // N
    step(); start = 1'b0;                   // N+1
    step();                                 // N+2
    step();                                 // N+3
    rst = 1'b1;
    step();                                 // N+4
    check("rst busy",   {31'b0, busy}, 32'd0);
    check("rst done",   {31'b0, done}, 32'd0);
    check("rst result", result,        32'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst no done", {31'b0, done}, 32'd0);
    end

    // Back-to-back with start held high through DONE
    issue(32'hABCD_0000, 5'd16, 1'b0, 32'h0000_ABCD);   // N
    step();                                             // N+1
`ifdef SHR_SRA_EN
    sb_q.push_back(32'hFFFF_FFFF);
`else
    sb_q.push_back(32'h0000_000F);
`endif
    a = 32'hF000_0000; shiftamt = 5'd28; arith = 1'b1;
    wait_done(1, "b2b op1");                            // N+6
    step();                                             // N+7
    start = 1'b0;
    for (int i = 7; i <= 11; i++) begin
      check("b2b busy",        {31'b0, busy}, 32'd1);
      check("b2b done low",    {31'b0, done}, 32'd0);
      check("b2b result hold", result,        32'h0000_ABCD);
      step();
    end
    check("b2b op2 done", {31'b0, done}, 32'd1);        // N+12
    pop_check("b2b op2");
    step();
    check("b2b end done", {31'b0, done}, 32'd0);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
